uart_cmd_ahb_sequencer: RTL and testbench

Command-frame sequencer between the UART byte receiver/transmitter and the AHB-Lite bus, feeding the flash-writer slave.

---
 rtl/uart_ahb_pkg.sv | 26 ++
 rtl/uart_byte_shifter.sv | 38 +++
 rtl/uart_cmd_ahb_sequencer.sv | 178 +++++++++++++++++
 tb/tb_uart_cmd_ahb_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ahb_pkg.sv
// Shared definitions for the UART command sequencer: opcodes, AHB-Lite
// encodings and the sequencer state enum.
package uart_ahb_pkg;

  localparam logic [7:0] CMD_WR = 8'hA3;
  localparam logic [7:0] CMD_RD = 8'hA5;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_AHB_ADDR,
    ST_AHB_DATA,
    ST_SEND
  } seq_state_t;

  // True for the two bytes that open a frame; everything else is noise in IDLE.
  function automatic logic is_opcode(input logic [7:0] b);
    return (b == CMD_WR) || (b == CMD_RD);
  endfunction

endpackage

// File: rtl/uart_byte_shifter.sv
// Generic 4-byte little-endian register. Shifting moves every byte one lane
// toward bit 0 and brings byte_in in at the top, so four shifts assemble a
// word whose first byte lands in [7:0]; with byte_in tied to zero the same
// shift serializes a parallel-loaded word LSB first out of [7:0].
module uart_byte_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  input  logic [31:0] word_in,
  output logic [31:0] word,
  output logic        last
);

  logic [1:0] count;

  // Parallel load restarts the byte count; each shift advances it and the
  // 2-bit counter wraps 3->0 after the fourth byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      word  <= 32'h0;
      count <= 2'd0;
    end else if (load) begin
      word  <= word_in;
      count <= 2'd0;
    end else if (shift) begin
      word  <= {byte_in, word[31:8]};
      count <= count + 2'd1;
    end else if (clear) begin
      count <= 2'd0;
    end
  end

  assign last = (count == 2'd3);

endmodule

// File: rtl/uart_cmd_ahb_sequencer.sv
// Command-frame sequencer between the UART byte interface and AHB-Lite.
// 0xA3 frames (4 address + 4 data bytes) issue a single-beat word write,
// 0xA5 frames (4 address bytes) issue a word read whose result is returned
// LSB first to the UART transmitter.
// Build option CMD_TIMEOUT_EN: abort a partial frame after TIMEOUT_CYCLES
// idle cycles between bytes; without it a partial frame waits forever.
module uart_cmd_ahb_sequencer
  import uart_ahb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  output logic        busy,
  output logic        rx_drop
);

  seq_state_t  state;
  logic        write_flag;
  logic        timeout_hit;

  logic        rx_shift, rx_clear, rx_last;
  logic [31:0] rx_word;
  logic        tx_load, tx_shift, tx_last;
  logic [31:0] tx_word;
  logic        unused_ok;

  assign rx_shift = rx_valid && ((state == ST_GET_ADDR) || (state == ST_GET_DATA));
  assign rx_clear = ((state == ST_IDLE) && rx_valid && is_opcode(rx_data)) || timeout_hit;
  assign tx_load  = (state == ST_AHB_DATA) && HREADY && !write_flag;
  assign tx_shift = (state == ST_SEND) && tx_valid && tx_ready;

  uart_byte_shifter rx_shifter (
    .clk     (HCLK),
    .reset   (HRESET),
    .clear   (rx_clear),
    .load    (1'b0),
    .shift   (rx_shift),
    .byte_in (rx_data),
    .word_in (32'h0),
    .word    (rx_word),
    .last    (rx_last)
  );

  uart_byte_shifter tx_shifter (
    .clk     (HCLK),
    .reset   (HRESET),
    .clear   (1'b0),
    .load    (tx_load),
    .shift   (tx_shift),
    .byte_in (8'h00),
    .word_in (HRDATA),
    .word    (tx_word),
    .last    (tx_last)
  );

  assign tx_data = tx_word[7:0];
  assign HSIZE   = HSIZE_WORD;
  assign busy    = (state != ST_IDLE);

  // The oldest received byte and the already-sent read-back bytes are never
  // looked at directly; they are collected here so they read as intentional.
  assign unused_ok = ^{rx_word[7:0], tx_word[31:8], (TIMEOUT_CYCLES > 0)};

`ifdef CMD_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_cnt;

  assign timeout_hit = ((state == ST_GET_ADDR) || (state == ST_GET_DATA)) && !rx_valid &&
                       (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  // Count idle cycles between frame bytes; held at zero outside the receive states.
  always_ff @(posedge HCLK) begin
    if (HRESET || rx_valid || timeout_hit ||
        !((state == ST_GET_ADDR) || (state == ST_GET_DATA))) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Frame parser, AHB-Lite master and read-back sender in one registered FSM.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= ST_IDLE;
      write_flag <= 1'b0;
      HADDR      <= 32'h0;
      HWDATA     <= 32'h0;
      HTRANS     <= HTRANS_IDLE;
      HWRITE     <= 1'b0;
      tx_valid   <= 1'b0;
      rx_drop    <= 1'b0;
    end else begin
      rx_drop <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_valid && (rx_data == CMD_WR)) begin
            write_flag <= 1'b1;
            state      <= ST_GET_ADDR;
          end else if (rx_valid && (rx_data == CMD_RD)) begin
            write_flag <= 1'b0;
            state      <= ST_GET_ADDR;
          end
        end
        ST_GET_ADDR: begin
          if (rx_valid && rx_last) begin
            HADDR <= {rx_data, rx_word[31:8]};
            if (write_flag) begin
              state <= ST_GET_DATA;
            end else begin
              state  <= ST_AHB_ADDR;
              HTRANS <= HTRANS_NONSEQ;
              HWRITE <= 1'b0;
            end
          end else if (timeout_hit) begin
            state <= ST_IDLE;
          end
        end
        ST_GET_DATA: begin
          if (rx_valid && rx_last) begin
            HWDATA <= {rx_data, rx_word[31:8]};
            state  <= ST_AHB_ADDR;
            HTRANS <= HTRANS_NONSEQ;
            HWRITE <= 1'b1;
          end else if (timeout_hit) begin
            state <= ST_IDLE;
          end
        end
        ST_AHB_ADDR: begin
          rx_drop <= rx_valid;
          if (HREADY) begin
            HTRANS <= HTRANS_IDLE;
            state  <= ST_AHB_DATA;
          end
        end
        ST_AHB_DATA: begin
          rx_drop <= rx_valid;
          if (HREADY) begin
            HWRITE <= 1'b0;
            if (write_flag) begin
              state <= ST_IDLE;
            end else begin
              state    <= ST_SEND;
              tx_valid <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          rx_drop <= rx_valid;
          if (tx_valid && tx_ready && tx_last) begin
            tx_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          HTRANS <= HTRANS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ahb_sequencer.sv
// Self-checking bench for uart_cmd_ahb_sequencer. Acts as UART host, AHB-Lite
// slave (backed by a word memory model) and UART transmitter; directed frames
// first, then randomized frames with random wait states and tx stalls.
// Build option CMD_TIMEOUT_EN enables the inter-byte timeout scenario.
module tb_uart_cmd_ahb_sequencer;

  localparam logic [7:0]  OP_WR  = 8'hA3;
  localparam logic [7:0]  OP_RD  = 8'hA5;
  localparam logic [31:0] T_IDLE = 32'd0;
  localparam logic [31:0] T_NSEQ = 32'd2;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        busy;
  logic        rx_drop;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [31:0] mem_model [logic [31:0]];

  always #5 HCLK = ~HCLK;

  uart_cmd_ahb_sequencer #(.TIMEOUT_CYCLES(50)) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HWDATA   (HWDATA),
    .HRDATA   (HRDATA),
    .HREADY   (HREADY),
    .busy     (busy),
    .rx_drop  (rx_drop)
  );

  // Slave memory: written words come back, untouched words give a fixed pattern.
  function automatic logic [31:0] slave_word(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Present one byte for exactly one rising edge; returns on the following falling edge.
  task automatic sendByte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge HCLK);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // One full frame: send bytes, act as slave with the given wait states,
  // then (for reads) accept the four returned bytes with tx_stall stalls each.
  task automatic applyStimulus(input bit is_write, input logic [31:0] addr, input logic [31:0] data,
                               input int addr_waits, input int data_waits, input int tx_stall,
                               input bit inject_drop);
    logic [7:0]  frame[$];
    logic [31:0] expected_word;
    logic [7:0]  exp_byte;
    bit          poke;
    frame.push_back(is_write ? OP_WR : OP_RD);
    for (int i = 0; i < 4; i++) frame.push_back(8'(addr >> (8 * i)));
    if (is_write) for (int i = 0; i < 4; i++) frame.push_back(8'(data >> (8 * i)));
    expected_word = is_write ? data : slave_word(addr);

    for (int i = 0; i < frame.size(); i++) begin
      sendByte(frame[i]);
      checkOutput("busy_rx", 32'(busy), 32'd1);
      if (i < frame.size() - 1) checkOutput("htrans_rx", 32'(HTRANS), T_IDLE);
    end

    checkOutput("htrans_nonseq", 32'(HTRANS), T_NSEQ);
    checkOutput("haddr", HADDR, addr);
    checkOutput("hwrite", 32'(HWRITE), 32'(is_write));
    checkOutput("hsize", 32'(HSIZE), 32'd2);
    for (int w = 0; w < addr_waits; w++) begin
      HREADY = 1'b0;
      @(negedge HCLK);
      checkOutput("htrans_hold", 32'(HTRANS), T_NSEQ);
      checkOutput("haddr_hold", HADDR, addr);
    end
    HREADY = 1'b1;
    @(negedge HCLK);
    checkOutput("htrans_data", 32'(HTRANS), T_IDLE);
    if (is_write) checkOutput("hwdata", HWDATA, data);

    for (int w = 0; w < data_waits; w++) begin
      HREADY = 1'b0;
      HRDATA = $urandom;
      @(negedge HCLK);
      checkOutput("busy_dwait", 32'(busy), 32'd1);
      checkOutput("tx_valid_dwait", 32'(tx_valid), 32'd0);
      if (is_write) checkOutput("hwdata_hold", HWDATA, data);
    end
    HREADY = 1'b1;
    HRDATA = is_write ? 32'($urandom) : expected_word;
    @(negedge HCLK);
    HRDATA = $urandom;

    if (is_write) begin
      mem_model[addr] = data;
      checkOutput("busy_wr_done", 32'(busy), 32'd0);
      checkOutput("tx_valid_wr", 32'(tx_valid), 32'd0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_byte = 8'(expected_word >> (8 * i));
        checkOutput("tx_valid", 32'(tx_valid), 32'd1);
        checkOutput("tx_data", 32'(tx_data), 32'(exp_byte));
        for (int s = 0; s < tx_stall; s++) begin
          poke = inject_drop && (i == 1) && (s == 0);
          if (poke) begin
            rx_valid = 1'b1;
            rx_data  = 8'h77;
          end
          @(negedge HCLK);
          rx_valid = 1'b0;
          checkOutput("tx_data_stall", 32'(tx_data), 32'(exp_byte));
          checkOutput("rx_drop", 32'(rx_drop), 32'(poke));
        end
        tx_ready = 1'b1;
        @(negedge HCLK);
        tx_ready = 1'b0;
      end
      checkOutput("tx_valid_end", 32'(tx_valid), 32'd0);
      checkOutput("busy_rd_done", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    bit          rw;
    logic [31:0] ra;
    int          st;

    HRESET   = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    HRDATA   = 32'h0;
    HREADY   = 1'b1;
    repeat (3) @(negedge HCLK);
    $display("[TB] reset values");
    checkOutput("rst_htrans", 32'(HTRANS), T_IDLE);
    checkOutput("rst_hwrite", 32'(HWRITE), 32'd0);
    checkOutput("rst_haddr", HADDR, 32'd0);
    checkOutput("rst_hwdata", HWDATA, 32'd0);
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rx_drop", 32'(rx_drop), 32'd0);
    HRESET = 1'b0;
    @(negedge HCLK);

    $display("[TB] zero-wait write and read");
    applyStimulus(1'b1, 32'h0000_0008, 32'h0000_0001, 0, 0, 0, 1'b0);
    mem_model[32'h14] = 32'h1234_ABC5;
    applyStimulus(1'b0, 32'h0000_0014, 32'h0, 0, 0, 0, 1'b0);

    $display("[TB] wait states and read-back");
    applyStimulus(1'b0, 32'h0000_0014, 32'h0, 3, 2, 0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0008, 32'h0, 1, 1, 1, 1'b0);

    $display("[TB] tx stalls with dropped byte");
    applyStimulus(1'b0, 32'h0000_0014, 32'h0, 0, 0, 5, 1'b1);

    $display("[TB] noise byte then write");
    sendByte(8'h55);
    checkOutput("noise_busy", 32'(busy), 32'd0);
    @(negedge HCLK);
    checkOutput("noise_rx_drop", 32'(rx_drop), 32'd0);
    checkOutput("noise_htrans", 32'(HTRANS), T_IDLE);
    applyStimulus(1'b1, 32'hCAFE_0010, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);

    $display("[TB] reset mid-frame");
    sendByte(OP_WR);
    sendByte(8'h11);
    sendByte(8'h22);
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_haddr", HADDR, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge HCLK);
      checkOutput("midrst_htrans", 32'(HTRANS), T_IDLE);
    end
    applyStimulus(1'b1, 32'h0000_0020, 32'h0BAD_F00D, 1, 1, 0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0020, 32'h0, 0, 0, 2, 1'b0);

    $display("[TB] reset mid-transfer");
    sendByte(OP_RD);
    for (int i = 0; i < 4; i++) sendByte(8'(32'h40 >> (8 * i)));
    checkOutput("xfer_nonseq", 32'(HTRANS), T_NSEQ);
    HREADY = 1'b0;
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    HREADY = 1'b1;
    checkOutput("xfer_rst_htrans", 32'(HTRANS), T_IDLE);
    checkOutput("xfer_rst_busy", 32'(busy), 32'd0);
    @(negedge HCLK);

`ifdef CMD_TIMEOUT_EN
    $display("[TB] inter-byte timeout");
    sendByte(OP_RD);
    sendByte(8'h14);
    for (int c = 1; c <= 60; c++) begin
      @(negedge HCLK);
      checkOutput("to_htrans", 32'(HTRANS), T_IDLE);
      if (c == 49) checkOutput("to_busy_before", 32'(busy), 32'd1);
      if (c == 50) checkOutput("to_busy_after", 32'(busy), 32'd0);
    end
    sendByte(8'h00);
    sendByte(8'h00);
    checkOutput("to_trail_busy", 32'(busy), 32'd0);
    @(negedge HCLK);
    checkOutput("to_trail_htrans", 32'(HTRANS), T_IDLE);
    applyStimulus(1'b0, 32'h0000_0014, 32'h0, 0, 0, 0, 1'b0);
`endif

    $display("[TB] randomized frames");
    for (int n = 0; n < 24; n++) begin
      rw = 1'($urandom_range(0, 1));
      ra = (n % 5 == 4) ? $urandom : 32'h100 + 32'(4 * $urandom_range(0, 3));
      st = int'($urandom_range(0, 3));
      applyStimulus(rw, ra, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    st, (st >= 2) && ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
